// File: rtl/eth_tx_pkg.sv
// Shared types and defaults for the GMII transmit arbiter.
// Holds the FSM state encoding, counter widths and the saturating increment helper.
package eth_tx_pkg;

   localparam int IFG_DEFAULT     = 12;
   localparam int MAX_LEN_DEFAULT = 1536;
   localparam int BYTE_CNT_W      = 11;
   localparam int ABORT_CNT_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GRANT = 3'd1,
      ST_SEND  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_GAP   = 3'd4
   } tx_state_e;

   typedef struct packed {
      logic       en;
      logic [7:0] data;
   } lane_t;

   function automatic logic [ABORT_CNT_W-1:0] sat_inc(input logic [ABORT_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. The pointer names the favoured requester and
// moves to the other one whenever the current owner is accepted into a frame.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   input  logic       accept_id_i,
   output logic       valid_o,
   output logic       pick_o
);

   logic ptr_q;

   always_comb begin
      valid_o = |req_i;
      pick_o  = req_i[ptr_q] ? ptr_q : ~ptr_q;
   end

   // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else if (accept_i) begin
         ptr_q <= ~accept_id_i;
      end
   end

endmodule

// File: rtl/gmii_tx_arb.sv
// Two-requester GMII transmit arbiter: round-robin grant, one-cycle registered
// datapath, length abort with tx_er, and an enforced inter-frame gap.
module gmii_tx_arb
   import eth_tx_pkg::*;
#(
   parameter int IFG     = IFG_DEFAULT,
   parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
   input  logic       tx_clk,
   input  logic       tx_rstn,
   input  logic       req0,
   input  logic       req1,
   output logic       gnt0,
   output logic       gnt1,
   input  logic [7:0] txd0,
   input  logic [7:0] txd1,
   input  logic       tx_en0,
   input  logic       tx_en1,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       busy,
   output logic [7:0] abort_cnt
);

   localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;
   localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(IFG - 1);
   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(MAX_LEN - 1);

   tx_state_e              state_q;
   logic                   sel_q;
   logic                   gnt0_q;
   logic                   gnt1_q;
   logic [7:0]             gmii_txd_q;
   logic                   gmii_tx_en_q;
   logic                   gmii_tx_er_q;
   logic [ABORT_CNT_W-1:0] abort_cnt_q;
   logic [BYTE_CNT_W-1:0]  byte_cnt_q;
   logic [GAP_W-1:0]       gap_cnt_q;

   lane_t sel_lane;
   logic  sel_req;
   logic  arb_valid;
   logic  arb_pick;
   logic  accept;

   // Only the granted requester's lane is ever looked at downstream.
   always_comb begin
      sel_lane = '{en: tx_en0, data: txd0};
      sel_req  = req0;
      if (sel_q) begin
         sel_lane = '{en: tx_en1, data: txd1};
         sel_req  = req1;
      end
   end

   assign accept = (state_q == ST_GRANT) && sel_lane.en;

   rr_arb2 u_arb (
      .clk         (tx_clk),
      .rst_n       (tx_rstn),
      .req_i       ({req1, req0}),
      .accept_i    (accept),
      .accept_id_i (sel_q),
      .valid_o     (arb_valid),
      .pick_o      (arb_pick)
   );

   always_ff @(posedge tx_clk) begin
      if (!tx_rstn) begin
         state_q      <= ST_IDLE;
         sel_q        <= 1'b0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         gmii_txd_q   <= '0;
         gmii_tx_en_q <= 1'b0;
         gmii_tx_er_q <= 1'b0;
         abort_cnt_q  <= '0;
         byte_cnt_q   <= '0;
         gap_cnt_q    <= '0;
      end else begin
         // NOTE: the output registers default to idle every cycle; only states that forward a byte override them.
         gmii_txd_q   <= '0;
         gmii_tx_en_q <= 1'b0;
         gmii_tx_er_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  sel_q   <= arb_pick;
                  gnt0_q  <= ~arb_pick;
                  gnt1_q  <= arb_pick;
                  state_q <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (sel_lane.en) begin
                  gmii_txd_q   <= sel_lane.data;
                  gmii_tx_en_q <= 1'b1;
                  byte_cnt_q   <= BYTE_CNT_W'(1);
                  state_q      <= ST_SEND;
               end else if (!sel_req) begin
                  gnt0_q    <= 1'b0;
                  gnt1_q    <= 1'b0;
                  gap_cnt_q <= '0;
                  state_q   <= ST_GAP;
               end
            end
            ST_SEND: begin
               if (sel_lane.en) begin
                  gmii_txd_q   <= sel_lane.data;
                  gmii_tx_en_q <= 1'b1;
                  byte_cnt_q   <= byte_cnt_q + 1'b1;
                  // The byte that reaches MAX_LEN goes out flagged, then the rest is swallowed.
                  if (byte_cnt_q == LAST_BYTE) begin
                     gmii_tx_er_q <= 1'b1;
                     abort_cnt_q  <= sat_inc(abort_cnt_q);
                     state_q      <= ST_DRAIN;
                  end
               end else begin
                  gnt0_q    <= 1'b0;
                  gnt1_q    <= 1'b0;
                  gap_cnt_q <= '0;
                  state_q   <= ST_GAP;
               end
            end
            ST_DRAIN: begin
               if (!sel_lane.en) begin
                  gnt0_q    <= 1'b0;
                  gnt1_q    <= 1'b0;
                  gap_cnt_q <= '0;
                  state_q   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_q <= ST_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign gmii_txd   = gmii_txd_q;
   assign gmii_tx_en = gmii_tx_en_q;
   assign gmii_tx_er = gmii_tx_er_q;
   assign abort_cnt  = abort_cnt_q;
   assign busy       = (state_q != ST_IDLE);

   a_gnt_onehot : assert property (@(posedge tx_clk) disable iff (!tx_rstn)
      !(gnt0_q && gnt1_q));
   a_er_with_en : assert property (@(posedge tx_clk) disable iff (!tx_rstn)
      gmii_tx_er_q |-> gmii_tx_en_q);

endmodule

// File: tb/tb_gmii_tx_arb.sv
// Directed bench for gmii_tx_arb: reset, single frame, contention, alternation,
// length abort, empty grant and mid-frame reset, with a passive frame monitor.
module tb_gmii_tx_arb;

   localparam int IFG     = 12;
   localparam int MAX_LEN = 64;

   logic       tx_clk = 1'b0;
   logic       tx_rstn;
   logic       req0, req1, tx_en0, tx_en1;
   logic [7:0] txd0, txd1;
   logic       gnt0, gnt1, gmii_tx_en, gmii_tx_er, busy;
   logic [7:0] gmii_txd, abort_cnt;

   always #4 tx_clk = ~tx_clk;

   gmii_tx_arb #(.IFG(IFG), .MAX_LEN(MAX_LEN)) dut (
      .tx_clk     (tx_clk),
      .tx_rstn    (tx_rstn),
      .req0       (req0),
      .req1       (req1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .txd0       (txd0),
      .txd1       (txd1),
      .tx_en0     (tx_en0),
      .tx_en1     (tx_en1),
      .gmii_txd   (gmii_txd),
      .gmii_tx_en (gmii_tx_en),
      .gmii_tx_er (gmii_tx_er),
      .busy       (busy),
      .abort_cnt  (abort_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   // Passive monitor: splits the GMII output into frames at each negedge.
   int         cyc = 0;
   int         nfr = 0;
   bit         in_fr = 1'b0;
   int         idle_run = 1000;
   int         er_total = 0;
   int         er_noen = 0;
   int         gnt_both = 0;
   int         idle_txd_bad = 0;
   int         fr_len[16];
   int         fr_owner[16];
   int         fr_gap[16];
   int         fr_start[16];
   int         fr_er_idx[16];
   logic [7:0] fr_data[16][128];

   always @(negedge tx_clk) begin
      cyc++;
      if (gnt0 && gnt1) gnt_both++;
      if (gmii_tx_er) er_total++;
      if (gmii_tx_er && !gmii_tx_en) er_noen++;
      if (gmii_tx_en) begin
         if (!in_fr) begin
            in_fr = 1'b1;
            if (nfr < 16) begin
               fr_len[nfr]    = 0;
               fr_owner[nfr]  = gnt1 ? 1 : 0;
               fr_gap[nfr]    = idle_run;
               fr_start[nfr]  = cyc;
               fr_er_idx[nfr] = -1;
            end
            nfr++;
         end
         idle_run = 0;
         if (nfr <= 16) begin
            if (fr_len[nfr-1] < 128) fr_data[nfr-1][fr_len[nfr-1]] = gmii_txd;
            if (gmii_tx_er) fr_er_idx[nfr-1] = fr_len[nfr-1];
            fr_len[nfr-1]++;
         end
      end else begin
         in_fr = 1'b0;
         idle_run++;
         if (gmii_txd != 8'h00) idle_txd_bad++;
      end
   end

   // Scripted requesters: raise req, start bytes on the cycle gnt is seen.
   int         pend[2];
   int         left[2];
   int         idx[2];
   bit         sending[2];
   logic [7:0] base[2];
   int         flen;

   task automatic drive_lane(input int w, input logic en, input logic [7:0] d);
      if (w == 0) begin tx_en0 = en; txd0 = d; end
      else        begin tx_en1 = en; txd1 = d; end
   endtask

   task automatic set_req(input int w, input logic r);
      if (w == 0) req0 = r;
      else        req1 = r;
   endtask

   task automatic tick_req();
      for (int w = 0; w < 2; w++) begin
         if (sending[w]) begin
            if (left[w] > 0) begin
               drive_lane(w, 1'b1, 8'(base[w] + 8'(idx[w])));
               idx[w]++;
               left[w]--;
            end else begin
               drive_lane(w, 1'b0, 8'h00);
               sending[w] = 1'b0;
               pend[w]--;
               set_req(w, pend[w] > 0);
            end
         end else if (pend[w] > 0) begin
            set_req(w, 1'b1);
            if ((w == 0) ? gnt0 : gnt1) begin
               sending[w] = 1'b1;
               drive_lane(w, 1'b1, base[w]);
               idx[w]  = 1;
               left[w] = flen - 1;
            end
         end
      end
   endtask

   task automatic step();
      @(negedge tx_clk);
      #1;
      tick_req();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_done(input string tag, input int budget);
      int k;
      k = 0;
      while ((pend[0] != 0 || pend[1] != 0 || sending[0] || sending[1]) && k < budget) begin
         step();
         k++;
      end
      check({tag, "_done"}, 32'(k < budget), 1);
   endtask

   function automatic int data_errs(input int f, input logic [7:0] b0, input logic [7:0] b1);
      int e;
      e = 0;
      for (int i = 0; i < fr_len[f] && i < 128; i++)
         if (fr_data[f][i] !== 8'(((fr_owner[f] == 1) ? b1 : b0) + 8'(i))) e++;
      return e;
   endfunction

   task automatic do_reset(input string tag);
      tx_rstn = 1'b0;
      req0 = 1'b0; req1 = 1'b0; tx_en0 = 1'b0; tx_en1 = 1'b0; txd0 = '0; txd1 = '0;
      for (int w = 0; w < 2; w++) begin pend[w] = 0; sending[w] = 1'b0; end
      step();
      step();
      check({tag, "_gnt0"},  32'(gnt0), 0);
      check({tag, "_gnt1"},  32'(gnt1), 0);
      check({tag, "_txen"},  32'(gmii_tx_en), 0);
      check({tag, "_txer"},  32'(gmii_tx_er), 0);
      check({tag, "_txd"},   32'(gmii_txd), 0);
      check({tag, "_busy"},  32'(busy), 0);
      check({tag, "_abort"}, 32'(abort_cnt), 0);
      tx_rstn = 1'b1;
      step();
   endtask

   int c0;

   initial begin
      tx_rstn = 1'b0;
      req0 = 1'b0; req1 = 1'b0; tx_en0 = 1'b0; tx_en1 = 1'b0; txd0 = '0; txd1 = '0;
      for (int w = 0; w < 2; w++) begin pend[w] = 0; sending[w] = 1'b0; left[w] = 0; idx[w] = 0; base[w] = '0; end
      flen = 0;
      do_reset("R0");

      // A: single 60-byte frame 0x00..0x3B from requester 0.
      c0 = cyc;
      req0 = 1'b1;
      step();
      check("A_gnt0", 32'(gnt0), 1);
      check("A_gnt1", 32'(gnt1), 0);
      check("A_busy", 32'(busy), 1);
      for (int i = 0; i < 60; i++) begin
         tx_en0 = 1'b1;
         txd0   = 8'(i);
         step();
      end
      tx_en0 = 1'b0; txd0 = '0; req0 = 1'b0;
      step();
      check("A_gnt0_drop", 32'(gnt0), 0);
      idle(20);
      check("A_idle_busy", 32'(busy), 0);
      check("A_nframes", nfr, 1);
      check("A_owner", fr_owner[0], 0);
      check("A_len", fr_len[0], 60);
      // gnt one cycle after req, then first byte one cycle after it is driven.
      check("A_latency", fr_start[0] - c0, 2);
      check("A_data", data_errs(0, 8'h00, 8'h00), 0);
      check("A_no_er", er_total, 0);

      // B: simultaneous requests after reset; 0 first, then 1 after the gap.
      do_reset("R1");
      base[0] = 8'h40; base[1] = 8'h80; flen = 60;
      pend[0] = 1; pend[1] = 1;
      tick_req();
      run_done("B", 400);
      check("B_nframes", nfr, 3);
      check("B_owner_first", fr_owner[1], 0);
      check("B_owner_second", fr_owner[2], 1);
      check("B_len0", fr_len[1], 60);
      check("B_len1", fr_len[2], 60);
      // IFG gap cycles + one IDLE + one GRANT cycle of idle output.
      check("B_gap", fr_gap[2], IFG + 2);
      check("B_data", data_errs(1, 8'h40, 8'h80) + data_errs(2, 8'h40, 8'h80), 0);

      // C: both keep requesting two frames each; service alternates 0,1,0,1.
      idle(20);
      base[0] = 8'h10; base[1] = 8'hC0; flen = 20;
      pend[0] = 2; pend[1] = 2;
      tick_req();
      run_done("C", 800);
      check("C_nframes", nfr, 7);
      for (int f = 3; f < 7; f++) begin
         check($sformatf("C_owner%0d", f), fr_owner[f], (f - 3) % 2);
         check($sformatf("C_len%0d", f), fr_len[f], 20);
         if (f > 3) check($sformatf("C_gap%0d", f), fr_gap[f], IFG + 2);
      end
      check("C_data", data_errs(3, 8'h10, 8'hC0) + data_errs(4, 8'h10, 8'hC0)
                    + data_errs(5, 8'h10, 8'hC0) + data_errs(6, 8'h10, 8'hC0), 0);

      // D: 100-cycle tx_en0 against MAX_LEN=64 -> abort on byte 64, then drain.
      idle(20);
      req0 = 1'b1;
      step();
      check("D_gnt0", 32'(gnt0), 1);
      for (int i = 0; i < 100; i++) begin
         tx_en0 = 1'b1;
         txd0   = 8'(i);
         step();
      end
      check("D_gnt_drain", 32'(gnt0), 1);
      check("D_drain_idle", 32'(gmii_tx_en), 0);
      tx_en0 = 1'b0; txd0 = '0; req0 = 1'b0;
      step();
      check("D_gnt_drop", 32'(gnt0), 0);
      check("D_abort_cnt", 32'(abort_cnt), 1);
      check("D_nframes", nfr, 8);
      check("D_len", fr_len[7], 64);
      check("D_er_idx", fr_er_idx[7], 63);
      check("D_er_total", er_total, 1);
      check("D_data", data_errs(7, 8'h00, 8'h00), 0);

      // E: req1 pulse without tx_en1 -> GRANT, GAP for IFG cycles, IDLE.
      idle(20);
      req1 = 1'b1;
      step();
      check("E_gnt1", 32'(gnt1), 1);
      check("E_busy_grant", 32'(busy), 1);
      req1 = 1'b0;
      step();
      check("E_gnt1_drop", 32'(gnt1), 0);
      check("E_busy_gap", 32'(busy), 1);
      idle(IFG - 1);
      check("E_busy_gap_end", 32'(busy), 1);
      idle(1);
      check("E_busy_idle", 32'(busy), 0);
      check("E_no_frame", nfr, 8);

      // F: reset while byte 20 is presented, then a fresh 30-byte frame.
      req0 = 1'b1;
      step();
      for (int i = 0; i < 20; i++) begin
         tx_en0 = 1'b1;
         txd0   = 8'(8'h30 + 8'(i));
         step();
      end
      tx_rstn = 1'b0;
      txd0    = 8'h44;
      step();
      check("F_txen",  32'(gmii_tx_en), 0);
      check("F_txd",   32'(gmii_txd), 0);
      check("F_txer",  32'(gmii_tx_er), 0);
      check("F_gnt0",  32'(gnt0), 0);
      check("F_gnt1",  32'(gnt1), 0);
      check("F_busy",  32'(busy), 0);
      check("F_abort", 32'(abort_cnt), 0);
      tx_rstn = 1'b1; tx_en0 = 1'b0; txd0 = '0; req0 = 1'b0;
      idle(2);
      check("F_trunc_len", fr_len[8], 20);
      base[0] = 8'hA0; flen = 30;
      pend[0] = 1;
      tick_req();
      run_done("F", 200);
      idle(3);
      check("F_nframes", nfr, 10);
      check("F_owner", fr_owner[9], 0);
      check("F_len", fr_len[9], 30);
      check("F_data", data_errs(9, 8'hA0, 8'hA0), 0);
      check("F_er_total", er_total, 1);

      check("gnt_onehot", gnt_both, 0);
      check("idle_txd_zero", idle_txd_bad, 0);
      check("er_only_with_en", er_noen, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #(8 * 50000);
      $display("FAIL watchdog: observed cycle %0d, expected finish before it", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
